cpu_completion_ctrl: RTL and testbench
======================================

// Module: cpu_completion_ctrl
// PURPOSE
//  Stage-4 completion controller: next generation of the P4 result mux. Selects the writeback value
//  per op class, aligns and extends sub-word load data, and waits on memory/divider responses
//  through a small FSM. Captures one-cycle response pulses while downstream is held, times out on
//  lost responses, and counts stall cycles. Sits between P4 execute/memory outputs and the regfile write port.
// PARAMETERS
//  DATA_W      32   result width; >=32; loads sign/zero-extend to DATA_W
//  TIMEOUT     255  max wait cycles for mem/div response before fault; 0 disables the timeout
//  CNT_W       32   width of the saturating stall-cycle counter
// PORTS
//  clock          in   1       rising-edge clock
//  reset          in   1       asynchronous, active-low reset
//  p4_valid       in   1       op in P4 is live
//  p4_op          in   6       opcode (OP_* encodings)
//  p4_hold        in   1       downstream holds P4 this cycle
//  p4_addr_lo     in   2       load byte offset (low address bits)
//  p4_alu_out     in   DATA_W  ALU/link result
//  p4_mult        in   DATA_W  multiplier result
//  p4_quotient    in   DATA_W  divider quotient
//  p4_remainder   in   DATA_W  divider remainder
//  p4_divider_done in  1       divider result valid (level)
//  mem_rdata      in   32      load response data
//  mem_rvalid     in   1       load response, 1-cycle pulse
//  mem_wack       in   1       store ack, 1-cycle pulse
//  p4_data_out    out  DATA_W  writeback value
//  p4_wr_en       out  1       regfile write strobe (qualified by !stall & !p4_hold)
//  stall          out  1       hold upstream, op not complete
//  p4_fault       out  1       1-cycle timeout pulse
//  stall_cycles   out  CNT_W   saturating count of cycles with stall=1
// BEHAVIOUR
//  Reset: state IDLE, hold register 0, timeout counter 0; p4_data_out=0, p4_wr_en=0, stall=0,
//   p4_fault=0, stall_cycles=0. Reset mid-wait abandons the op; no fault is raised.
//  Op classes: ALU (AND..JMPR, LD) -> data=p4_alu_out, wr_en=1, 0 wait. MUL -> p4_mult, 0 wait.
//   LOAD (LDB/LDH/LDW/LDBU/LDHU), STORE (STB/STH/STW), DIV (DIVU/DIVS -> quotient,
//   MODU/MODS -> remainder). CFGR/CFGW/RTE/SYS/unknown -> wr_en=0, data=0, no stall.
//  Load align: byte lane = p4_addr_lo; half lane = p4_addr_lo[1]; LDB/LDH sign-extend, LDBU/LDHU
//   zero-extend, LDW sign-extends bit31 to DATA_W. Misaligned half/word uses lane 0 (no trap).
//  FSM states IDLE, WAIT, HELD, FAULT.
//   IDLE: long op (LOAD/STORE/DIV) with its response present same cycle (rvalid/wack/done)
//    -> complete in 0 wait, stall=0. Response absent -> WAIT, stall=1.
//   WAIT: stall=1. Response arrives -> stall=0 that cycle. If p4_hold=1 at the same time ->
//    capture the result into the hold register, go to HELD. Otherwise go to IDLE.
//   HELD: stall=0; output comes from the hold register. wr_en=1 for LOAD/DIV results.
//    Leave to IDLE on the first cycle with p4_hold=0.
//   Same rule in IDLE: 0-wait pulse response with p4_hold=1 -> capture, go to HELD.
//   Timeout: counter clears on entry to WAIT and increments each WAIT cycle. At TIMEOUT -> FAULT.
//   FAULT: one cycle; p4_fault=1, stall=0, wr_en=0; op retires as a bubble; -> IDLE.
//  A stray rvalid/wack in IDLE/HELD with no pending long op is ignored.
//  Divider done is a level: no capture needed, but HELD is still used for uniform timing.
//  stall_cycles increments on every stall=1 cycle and saturates at all-ones.
//  stall and p4_data_out are combinational from state + inputs; state, hold reg and counters are flops.
// STRUCTURE
//  Shared package cpu_pkg: comp_state_t enum {IDLE,WAIT,HELD,FAULT};
//   op-class enum {CLS_ALU,CLS_MUL,CLS_LOAD,CLS_STORE,CLS_DIV,CLS_NONE}; OP_* stay in cpu.vh.
//  Sub-module cpu_load_align: mem_rdata, addr_lo, op -> DATA_W extended value (pure comb).
// TESTING
//  ADD, alu_out=0x1234 -> data=0x1234, wr_en=1, stall=0, stall_cycles unchanged.
//  LDB, addr_lo=3, rvalid after 4 cycles with rdata=0x80FF_FF7F -> stall 4 cycles, data=0xFFFF_FF80,
//   stall_cycles=4.
//  LDHU, rvalid same cycle with rdata=0xBEEF_1234, addr_lo=2 -> 0 stall, data=0x0000_BEEF.
//  LDW, rvalid while p4_hold=1 for 3 cycles -> HELD; data stable at rdata until hold drops; single retire.
//  DIVS, divider_done never; TIMEOUT=8 -> 8 stall cycles, p4_fault pulse, wr_en=0, back to IDLE.
//  STW waiting; reset asserted in cycle 2 -> all outputs 0 immediately; next op completes normally.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared definitions for the P4 completion controller.
//   comp_state_t : completion FSM states
//   op_cls_t     : writeback class of a P4 opcode
//   OP_*         : 6-bit opcode encodings seen by stage 4
//   op_class()   : opcode -> op_cls_t decode
package cpu_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    HELD,
    FAULT
  } comp_state_t;

  typedef enum logic [2:0] {
    CLS_ALU,
    CLS_MUL,
    CLS_LOAD,
    CLS_STORE,
    CLS_DIV,
    CLS_NONE
  } op_cls_t;

  // ALU/link ops occupy the contiguous range OP_AND..OP_JMPR.
  localparam logic [5:0] OP_AND  = 6'h00;
  localparam logic [5:0] OP_ADD  = 6'h03;
  localparam logic [5:0] OP_JMPR = 6'h0F;
  localparam logic [5:0] OP_LD   = 6'h10;
  localparam logic [5:0] OP_MUL  = 6'h11;
  localparam logic [5:0] OP_LDB  = 6'h18;
  localparam logic [5:0] OP_LDH  = 6'h19;
  localparam logic [5:0] OP_LDW  = 6'h1A;
  localparam logic [5:0] OP_LDBU = 6'h1B;
  localparam logic [5:0] OP_LDHU = 6'h1C;
  localparam logic [5:0] OP_STB  = 6'h20;
  localparam logic [5:0] OP_STH  = 6'h21;
  localparam logic [5:0] OP_STW  = 6'h22;
  localparam logic [5:0] OP_DIVU = 6'h28;
  localparam logic [5:0] OP_DIVS = 6'h29;
  localparam logic [5:0] OP_MODU = 6'h2A;
  localparam logic [5:0] OP_MODS = 6'h2B;
  localparam logic [5:0] OP_CFGR = 6'h30;
  localparam logic [5:0] OP_CFGW = 6'h31;
  localparam logic [5:0] OP_RTE  = 6'h32;
  localparam logic [5:0] OP_SYS  = 6'h33;

  function automatic op_cls_t op_class(input logic [5:0] op);
    op_cls_t cls;
    cls = CLS_NONE;
    case (op) inside
      [OP_AND:OP_JMPR], OP_LD:                 cls = CLS_ALU;
      OP_MUL:                                  cls = CLS_MUL;
      OP_LDB, OP_LDH, OP_LDW, OP_LDBU, OP_LDHU: cls = CLS_LOAD;
      OP_STB, OP_STH, OP_STW:                  cls = CLS_STORE;
      OP_DIVU, OP_DIVS, OP_MODU, OP_MODS:      cls = CLS_DIV;
      OP_CFGR, OP_CFGW, OP_RTE, OP_SYS:        cls = CLS_NONE;
      default:                                 cls = CLS_NONE;
    endcase
    return cls;
  endfunction

endpackage

// File: rtl/cpu_load_align.sv
// Load data alignment and extension (purely combinational).
//   mem_rdata : raw 32-bit load response
//   addr_lo   : byte offset of the load
//   op        : load opcode (selects size and signedness)
//   data      : aligned, extended value, DATA_W bits
module cpu_load_align
  import cpu_pkg::*;
#(
  parameter int unsigned DATA_W = 32
) (
  input  logic [31:0]       mem_rdata,
  input  logic [1:0]        addr_lo,
  input  logic [5:0]        op,
  output logic [DATA_W-1:0] data
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  always_comb begin
    byte_v = mem_rdata[7:0];
    case (addr_lo)
      2'd0: byte_v = mem_rdata[7:0];
      2'd1: byte_v = mem_rdata[15:8];
      2'd2: byte_v = mem_rdata[23:16];
      2'd3: byte_v = mem_rdata[31:24];
      default: byte_v = mem_rdata[7:0];
    endcase
    // Only offset 2 selects the upper half; an odd offset falls back to lane 0.
    half_v = (addr_lo == 2'b10) ? mem_rdata[31:16] : mem_rdata[15:0];
  end

  // Fill the whole word with the extension bit, then overlay the payload.
  always_comb begin
    data = {DATA_W{mem_rdata[31]}};
    data[31:0] = mem_rdata;
    case (op)
      OP_LDB: begin
        data = {DATA_W{byte_v[7]}};
        data[7:0] = byte_v;
      end
      OP_LDBU: begin
        data = '0;
        data[7:0] = byte_v;
      end
      OP_LDH: begin
        data = {DATA_W{half_v[15]}};
        data[15:0] = half_v;
      end
      OP_LDHU: begin
        data = '0;
        data[15:0] = half_v;
      end
      default: begin
        data = {DATA_W{mem_rdata[31]}};
        data[31:0] = mem_rdata;
      end
    endcase
  end

endmodule

// File: rtl/cpu_completion_ctrl.sv
// Stage-4 completion controller: picks the writeback value per op class,
// waits on memory/divider responses, captures pulse responses while the
// downstream holds P4, raises a one-cycle fault on a lost response, and
// counts stall cycles.
//   clock, reset (async, active-low)
//   p4_*            : op and results from execute/memory
//   mem_rdata/rvalid/wack : memory responses (rvalid/wack are 1-cycle pulses)
//   p4_data_out, p4_wr_en : regfile write port
//   stall           : hold upstream, op not complete
//   p4_fault        : 1-cycle timeout pulse
//   stall_cycles    : saturating count of stall=1 cycles
module cpu_completion_ctrl
  import cpu_pkg::*;
#(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned CNT_W   = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              p4_valid,
  input  logic [5:0]        p4_op,
  input  logic              p4_hold,
  input  logic [1:0]        p4_addr_lo,
  input  logic [DATA_W-1:0] p4_alu_out,
  input  logic [DATA_W-1:0] p4_mult,
  input  logic [DATA_W-1:0] p4_quotient,
  input  logic [DATA_W-1:0] p4_remainder,
  input  logic              p4_divider_done,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_rvalid,
  input  logic              mem_wack,
  output logic [DATA_W-1:0] p4_data_out,
  output logic              p4_wr_en,
  output logic              stall,
  output logic              p4_fault,
  output logic [CNT_W-1:0]  stall_cycles
);

  // Wait counter only needs to reach TIMEOUT-2 (see timeout_hit).
  localparam int unsigned TO_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  comp_state_t       state_reg, state_next;
  logic [TO_W-1:0]   to_cnt_reg, to_cnt_next;
  logic [DATA_W-1:0] hold_data_reg;
  logic              hold_wr_reg;
  logic              capture;

  op_cls_t           cls;
  logic              long_op, resp, writes, timeout_hit;
  logic [DATA_W-1:0] load_val, result;
  logic [DATA_W-1:0] data_c;
  logic              wr_c, stall_c, fault_c;

  cpu_load_align #(.DATA_W(DATA_W)) u_align (
    .mem_rdata (mem_rdata),
    .addr_lo   (p4_addr_lo),
    .op        (p4_op),
    .data      (load_val)
  );

  assign cls     = p4_valid ? op_class(p4_op) : CLS_NONE;
  assign long_op = (cls == CLS_LOAD) || (cls == CLS_STORE) || (cls == CLS_DIV);
  assign writes  = (cls == CLS_ALU) || (cls == CLS_MUL) || (cls == CLS_LOAD) || (cls == CLS_DIV);
  assign resp    = ((cls == CLS_LOAD)  && mem_rvalid) ||
                   ((cls == CLS_STORE) && mem_wack)   ||
                   ((cls == CLS_DIV)   && p4_divider_done);

  // The first stall cycle is spent in IDLE, so the k-th WAIT cycle (counter
  // k-1) is stall cycle k+1; fault after exactly TIMEOUT stall cycles.
  assign timeout_hit = (TIMEOUT != 0) && ((32'(to_cnt_reg) + 32'd2) >= 32'(TIMEOUT));

  always_comb begin
    result = '0;
    case (cls)
      CLS_ALU:  result = p4_alu_out;
      CLS_MUL:  result = p4_mult;
      CLS_LOAD: result = load_val;
      CLS_DIV:  result = ((p4_op == OP_MODU) || (p4_op == OP_MODS)) ? p4_remainder : p4_quotient;
      default:  result = '0;
    endcase
  end

  always_comb begin
    state_next  = state_reg;
    to_cnt_next = to_cnt_reg;
    data_c      = result;
    wr_c        = 1'b0;
    stall_c     = 1'b0;
    fault_c     = 1'b0;
    capture     = 1'b0;
    case (state_reg)
      IDLE: begin
        if (long_op) begin
          if (resp) begin
            if (p4_hold) begin
              capture    = 1'b1;
              state_next = HELD;
            end else begin
              wr_c = writes;
            end
          end else begin
            stall_c     = 1'b1;
            to_cnt_next = '0;
            state_next  = (TIMEOUT == 1) ? FAULT : WAIT;
          end
        end else begin
          wr_c = writes && !p4_hold;
        end
      end
      WAIT: begin
        if (!long_op) begin
          // Op vanished from P4; nothing left to wait for.
          state_next = IDLE;
        end else if (resp) begin
          if (p4_hold) begin
            capture    = 1'b1;
            state_next = HELD;
          end else begin
            wr_c       = writes;
            state_next = IDLE;
          end
        end else begin
          stall_c = 1'b1;
          if (timeout_hit) begin
            state_next = FAULT;
          end else begin
            to_cnt_next = to_cnt_reg + TO_W'(1);
          end
        end
      end
      HELD: begin
        data_c = hold_data_reg;
        wr_c   = hold_wr_reg && !p4_hold;
        if (!p4_hold) begin
          state_next = IDLE;
        end
      end
      FAULT: begin
        data_c     = '0;
        fault_c    = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // While reset is asserted the outputs read zero regardless of inputs.
  assign p4_data_out = reset ? data_c  : '0;
  assign p4_wr_en    = reset && wr_c;
  assign stall       = reset && stall_c;
  assign p4_fault    = reset && fault_c;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_reg     <= IDLE;
      to_cnt_reg    <= '0;
      hold_data_reg <= '0;
      hold_wr_reg   <= 1'b0;
      stall_cycles  <= '0;
    end else begin
      state_reg  <= state_next;
      to_cnt_reg <= to_cnt_next;
      if (capture) begin
        hold_data_reg <= result;
        hold_wr_reg   <= writes;
      end
      if (stall_c && (stall_cycles != '1)) begin
        stall_cycles <= stall_cycles + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_cpu_completion_ctrl.sv
// Directed bench for cpu_completion_ctrl (TIMEOUT=8, 5-bit stall counter).
module tb_cpu_completion_ctrl;
  import cpu_pkg::*;

  localparam int unsigned DW = 32;
  localparam int unsigned CW = 5;
  localparam int unsigned TO = 8;

  logic          clock = 1'b0;
  logic          reset;
  logic          p4_valid;
  logic [5:0]    p4_op;
  logic          p4_hold;
  logic [1:0]    p4_addr_lo;
  logic [DW-1:0] p4_alu_out, p4_mult, p4_quotient, p4_remainder;
  logic          p4_divider_done;
  logic [31:0]   mem_rdata;
  logic          mem_rvalid, mem_wack;
  logic [DW-1:0] p4_data_out;
  logic          p4_wr_en, stall, p4_fault;
  logic [CW-1:0] stall_cycles;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clock = ~clock;

  cpu_completion_ctrl #(.DATA_W(DW), .TIMEOUT(TO), .CNT_W(CW)) dut (
    .clock           (clock),
    .reset           (reset),
    .p4_valid        (p4_valid),
    .p4_op           (p4_op),
    .p4_hold         (p4_hold),
    .p4_addr_lo      (p4_addr_lo),
    .p4_alu_out      (p4_alu_out),
    .p4_mult         (p4_mult),
    .p4_quotient     (p4_quotient),
    .p4_remainder    (p4_remainder),
    .p4_divider_done (p4_divider_done),
    .mem_rdata       (mem_rdata),
    .mem_rvalid      (mem_rvalid),
    .mem_wack        (mem_wack),
    .p4_data_out     (p4_data_out),
    .p4_wr_en        (p4_wr_en),
    .stall           (stall),
    .p4_fault        (p4_fault),
    .stall_cycles    (stall_cycles)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Sample on the falling edge and compare the four writeback-side outputs.
  task automatic chk_out(input string tag, input logic [31:0] d, input logic w,
                         input logic s, input logic f);
    @(negedge clock);
    $display("txn %-12s op=%02h data=%08h wr_en=%0b stall=%0b fault=%0b stall_cycles=%0d",
             tag, p4_op, p4_data_out, p4_wr_en, stall, p4_fault, stall_cycles);
    chk({tag, ".data"},  p4_data_out, d);
    chk({tag, ".wr_en"}, 32'(p4_wr_en), 32'(w));
    chk({tag, ".stall"}, 32'(stall), 32'(s));
    chk({tag, ".fault"}, 32'(p4_fault), 32'(f));
  endtask

  task automatic next();
    @(posedge clock);
    #1;
  endtask

  task automatic drive_op(input logic [5:0] op);
    p4_valid = 1'b1;
    p4_op    = op;
  endtask

  initial begin
    reset = 1'b0;
    p4_valid = 1'b0; p4_op = OP_SYS; p4_hold = 1'b0; p4_addr_lo = 2'd0;
    p4_alu_out = '0; p4_mult = '0; p4_quotient = '0; p4_remainder = '0;
    p4_divider_done = 1'b0; mem_rdata = '0; mem_rvalid = 1'b0; mem_wack = 1'b0;

    // Reset state with a live op present.
    drive_op(OP_LDW);
    repeat (2) @(posedge clock);
    chk_out("reset", 32'h0, 1'b0, 1'b0, 1'b0);
    chk("reset.sc", 32'(stall_cycles), 32'd0);
    next();
    reset = 1'b1;

    // Single-cycle classes.
    drive_op(OP_ADD); p4_alu_out = 32'h0000_1234;
    chk_out("add", 32'h0000_1234, 1'b1, 1'b0, 1'b0);
    chk("add.sc", 32'(stall_cycles), 32'd0);
    next();
    p4_hold = 1'b1;
    chk_out("add.hold", 32'h0000_1234, 1'b0, 1'b0, 1'b0);
    next();
    p4_hold = 1'b0; drive_op(OP_MUL); p4_mult = 32'hCAFE_0001;
    chk_out("mul", 32'hCAFE_0001, 1'b1, 1'b0, 1'b0);
    next();
    drive_op(OP_SYS); mem_rvalid = 1'b1; mem_rdata = 32'h1111_2222;
    chk_out("sys", 32'h0, 1'b0, 1'b0, 1'b0);
    next();
    mem_rvalid = 1'b0; drive_op(OP_ADD); p4_valid = 1'b0;
    chk_out("bubble", 32'h0, 1'b0, 1'b0, 1'b0);
    next();

    // LDB offset 3, response after 4 stall cycles.
    drive_op(OP_LDB); p4_addr_lo = 2'd3; mem_rdata = '0;
    for (int i = 0; i < 4; i++) begin
      chk_out($sformatf("ldb.w%0d", i), 32'h0, 1'b0, 1'b1, 1'b0);
      next();
    end
    mem_rvalid = 1'b1; mem_rdata = 32'h80FF_FF7F;
    chk_out("ldb.done", 32'hFFFF_FF80, 1'b1, 1'b0, 1'b0);
    chk("ldb.sc", 32'(stall_cycles), 32'd4);
    next();
    // Stray response with an ALU op is ignored; controller is back in IDLE.
    drive_op(OP_ADD); p4_alu_out = 32'h0000_0042;
    chk_out("add.stray", 32'h0000_0042, 1'b1, 1'b0, 1'b0);
    next();

    // Zero-wait loads, alignment and extension.
    drive_op(OP_LDHU); p4_addr_lo = 2'd2; mem_rdata = 32'hBEEF_1234; mem_rvalid = 1'b1;
    chk_out("ldhu", 32'h0000_BEEF, 1'b1, 1'b0, 1'b0);
    next();
    drive_op(OP_LDH); p4_addr_lo = 2'd2; mem_rdata = 32'h8000_1234;
    chk_out("ldh.hi", 32'hFFFF_8000, 1'b1, 1'b0, 1'b0);
    next();
    p4_addr_lo = 2'd1; mem_rdata = 32'h8000_9234;
    chk_out("ldh.mis", 32'hFFFF_9234, 1'b1, 1'b0, 1'b0);
    next();
    drive_op(OP_LDBU); p4_addr_lo = 2'd1; mem_rdata = 32'h0000_F100;
    chk_out("ldbu", 32'h0000_00F1, 1'b1, 1'b0, 1'b0);
    next();
    drive_op(OP_LDW); p4_addr_lo = 2'd3; mem_rdata = 32'h8765_4321;
    chk_out("ldw.mis", 32'h8765_4321, 1'b1, 1'b0, 1'b0);
    next();

    // LDW waits one cycle, response arrives under hold, held for 3 cycles.
    mem_rvalid = 1'b0; mem_rdata = '0; p4_addr_lo = 2'd0;
    chk_out("ldw.wait", 32'h0, 1'b0, 1'b1, 1'b0);
    next();
    mem_rvalid = 1'b1; mem_rdata = 32'hDEAD_BEEF; p4_hold = 1'b1;
    chk_out("ldw.cap", 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b0);
    next();
    mem_rvalid = 1'b0; mem_rdata = 32'h0;
    chk_out("ldw.held1", 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b0);
    next();
    chk_out("ldw.held2", 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b0);
    next();
    p4_hold = 1'b0;
    chk_out("ldw.retire", 32'hDEAD_BEEF, 1'b1, 1'b0, 1'b0);
    chk("ldw.sc", 32'(stall_cycles), 32'd5);
    next();
    drive_op(OP_ADD); p4_alu_out = 32'h0000_0005;
    chk_out("ldw.after", 32'h0000_0005, 1'b1, 1'b0, 1'b0);
    next();

    // Divider, done present the same cycle.
    drive_op(OP_DIVU); p4_quotient = 32'd7; p4_remainder = 32'd3; p4_divider_done = 1'b1;
    chk_out("divu", 32'd7, 1'b1, 1'b0, 1'b0);
    next();
    drive_op(OP_MODS);
    chk_out("mods", 32'd3, 1'b1, 1'b0, 1'b0);
    next();

    // DIVS never completes: 8 stall cycles, then a fault bubble.
    drive_op(OP_DIVS); p4_divider_done = 1'b0; p4_quotient = '0;
    for (int i = 0; i < 8; i++) begin
      chk_out($sformatf("divs.w%0d", i), 32'h0, 1'b0, 1'b1, 1'b0);
      next();
    end
    chk_out("divs.fault", 32'h0, 1'b0, 1'b0, 1'b1);
    chk("divs.sc", 32'(stall_cycles), 32'd13);
    next();
    drive_op(OP_ADD); p4_alu_out = 32'h0000_0077;
    chk_out("divs.after", 32'h0000_0077, 1'b1, 1'b0, 1'b0);
    next();

    // Two lost store acks push the counter to 29.
    for (int t = 0; t < 2; t++) begin
      drive_op(OP_STB);
      repeat (8) next();
      chk_out($sformatf("stb%0d.fault", t), 32'h0, 1'b0, 1'b0, 1'b1);
      next();
    end
    drive_op(OP_ADD);
    chk_out("add.mid", 32'h0000_0077, 1'b1, 1'b0, 1'b0);
    chk("sc.29", 32'(stall_cycles), 32'd29);
    next();

    // Four more stall cycles: counter saturates at 31.
    drive_op(OP_LDW); mem_rdata = 32'h0000_00AB;
    repeat (4) next();
    mem_rvalid = 1'b1;
    chk_out("ldw.sat", 32'h0000_00AB, 1'b1, 1'b0, 1'b0);
    chk("sc.sat", 32'(stall_cycles), 32'd31);
    next();
    mem_rvalid = 1'b0;

    // STW waiting; reset in its third cycle abandons it silently.
    drive_op(OP_STW);
    chk_out("stw.w0", 32'h0, 1'b0, 1'b1, 1'b0);
    next();
    chk_out("stw.w1", 32'h0, 1'b0, 1'b1, 1'b0);
    next();
    reset = 1'b0;
    chk_out("stw.rst", 32'h0, 1'b0, 1'b0, 1'b0);
    chk("stw.rst.sc", 32'(stall_cycles), 32'd0);
    next();
    reset = 1'b1; mem_wack = 1'b1;
    chk_out("stw.ack", 32'h0, 1'b0, 1'b0, 1'b0);
    next();
    mem_wack = 1'b0; drive_op(OP_ADD); p4_alu_out = 32'h0000_0099;
    chk_out("add.final", 32'h0000_0099, 1'b1, 1'b0, 1'b0);
    chk("final.sc", 32'(stall_cycles), 32'd0);
    next();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
